// File: rtl/sort_pkg.sv
// Shared constants for the in-memory sorter front-end.
package sort_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD      = 3'd1;
    localparam logic [ST_W-1:0] ST_KICK      = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd4;
    localparam logic [ST_W-1:0] ST_FINISH    = 3'd5;

endpackage

// File: rtl/sort_load_counter.sv
// Write-address counter for the loader, with a last-word flag
// against the latched array length.
module sort_load_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    input  logic [ADDR_W:0]   len_q,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W:0]   len_m1;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign len_m1 = len_q - {{ADDR_W{1'b0}}, 1'b1};
    assign count  = cnt_q;
    assign last   = ({1'b0, cnt_q} == len_m1);

endmodule

// File: rtl/sort_loader.sv
// Loader front-end: streams words into array memory, kicks the sorter.
// Optional running sum output enabled by SORT_LOADER_SUM_EN.
module sort_loader
    import sort_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_sel,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sort_start,
    input  logic              sort_done,
`ifdef SORT_LOADER_SUM_EN
    output logic [DATA_W+ADDR_W-1:0] sum,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [ST_W-1:0]   state_q;
    logic [ST_W-1:0]   state_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_d;
    logic              start_load;
    logic              xfer;
    logic              last;
    logic [ADDR_W-1:0] cnt;

    assign start_load = (state_q == ST_IDLE) && go;
    assign in_ready   = (state_q == ST_LOAD);
    assign xfer       = in_ready && in_valid;

    sort_load_counter #(
        .ADDR_W(ADDR_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(start_load),
        .inc  (xfer),
        .len_q(len_q),
        .count(cnt),
        .last (last)
    );

    // Lengths beyond the memory depth are clipped, not rejected.
    always_comb begin
        len_d = len_q;
        if (start_load) begin
            len_d = (len > DEPTH_L) ? DEPTH_L : len;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = (len != '0) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_LOAD: begin
                if (xfer && last) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK:      state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!sort_done) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (sort_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

`ifdef SORT_LOADER_SUM_EN
    logic [DATA_W+ADDR_W-1:0] sum_q;
    logic [DATA_W+ADDR_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_load) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + {{ADDR_W{1'b0}}, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`endif

    // Memory-facing outputs are forced to zero outside LOAD.
    assign mem_sel    = in_ready;
    assign mem_wr     = xfer;
    assign mem_addr   = in_ready ? cnt : '0;
    assign mem_wdata  = in_ready ? in_data : '0;
    assign sort_start = (state_q == ST_KICK);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);

endmodule

// File: tb/tb_sort_loader.sv
// Scoreboard bench for sort_loader with a simple sorter handshake model.
module tb_sort_loader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [AW:0]   len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_sel;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          sort_start;
    logic          sort_done;
    logic          busy;
    logic          done;
`ifdef SORT_LOADER_SUM_EN
    logic [DW+AW-1:0] sum;
`endif

    sort_loader #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_sel   (mem_sel),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .sort_start(sort_start),
        .sort_done (sort_done),
`ifdef SORT_LOADER_SUM_EN
        .sum       (sum),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  exp_sum_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  start_cnt = 0;
    int  done_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and sums as the DUT presents them.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (mem_wr) begin
                check("wr_sel", {31'd0, mem_sel}, 32'd1);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {28'd0, mem_addr}, {28'd0, e.addr});
                    check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
                end
            end
            if (sort_start) start_cnt++;
            if (done) begin
                done_cnt++;
`ifdef SORT_LOADER_SUM_EN
                n_tests++;
                if (exp_sum_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done_sum: got %0h", sum);
                end else begin
                    check("sum_at_done", {20'd0, sum}, exp_sum_q.pop_front());
                end
`endif
            end
        end
    end

    // Sorter model: leaves idle 2 cycles after the kick, busy 3 cycles.
    initial begin
        sort_done = 1'b1;
        forever begin
            @(negedge clk);
            if (sort_start) begin
                repeat (2) @(negedge clk);
                sort_done = 1'b0;
                repeat (3) @(negedge clk);
                sort_done = 1'b1;
            end
        end
    end

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.addr = a[AW-1:0];
        w.data = d[DW-1:0];
        exp_q.push_back(w);
    endtask

    task automatic do_go(input int l);
        @(posedge clk);
        #1;
        go  = 1'b1;
        len = l[AW:0];
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic send(input int d);
        in_valid = 1'b1;
        in_data  = d[DW-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic begin_test();
        start_cnt = 0;
        done_cnt  = 0;
    endtask

    task automatic end_test(input string name, input int exp_done,
                            input int exp_start);
        check({name, "_done_cnt"}, done_cnt, exp_done);
        check({name, "_start_cnt"}, start_cnt, exp_start);
        check({name, "_pending_wr"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst      = 1'b1;
        go       = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        @(negedge clk);
        in_valid = 1'b1;
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_ready",    {31'd0, in_ready},   32'd0);
        check("rst_sel",      {31'd0, mem_sel},    32'd0);
        check("rst_wr",       {31'd0, mem_wr},     32'd0);
        check("rst_start",    {31'd0, sort_start}, 32'd0);
        check("rst_done",     {31'd0, done},       32'd0);
        check("rst_addr",     {28'd0, mem_addr},   32'd0);
`ifdef SORT_LOADER_SUM_EN
        check("rst_sum",      {20'd0, sum},        32'd0);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset mid-LOAD after 3 of 8 words
        begin_test();
        do_go(8);
        push_wr(0, 8'hA1);
        push_wr(1, 8'hB2);
        push_wr(2, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA1 + 8'(i * 8'h11);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t1_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t1_busy",  {31'd0, busy},     32'd0);
        check("t1_ready", {31'd0, in_ready}, 32'd0);
        check("t1_sel",   {31'd0, mem_sel},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        end_test("t1", 0, 0);

        // 2: len=4 back-to-back, kick one cycle later, stray go ignored
        begin_test();
        exp_sum_q.push_back(20);
        do_go(4);
        push_wr(0, 9);
        push_wr(1, 3);
        push_wr(2, 7);
        push_wr(3, 1);
        in_valid = 1'b1;
        in_data  = 8'd9;
        @(posedge clk); #1; in_data = 8'd3;
        @(posedge clk); #1; in_data = 8'd7;
        @(posedge clk); #1; in_data = 8'd1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check("t2_kick", {31'd0, sort_start}, 32'd1);
        check("t2_kick_sel", {31'd0, mem_sel}, 32'd0);
        do_go(3);
        wait_idle("t2");
        repeat (3) @(negedge clk);
        check("t2_stay_idle", {31'd0, busy}, 32'd0);
`ifdef SORT_LOADER_SUM_EN
        check("t2_sum_hold", {20'd0, sum}, 32'd20);
`endif
        end_test("t2", 1, 1);

        // 3: len=5 with 2-cycle gaps
        begin_test();
        exp_sum_q.push_back(32'h0FF);
        do_go(5);
        for (int i = 0; i < 5; i++) begin
            push_wr(i, (i + 1) * 8'h11);
            send((i + 1) * 8'h11);
            repeat (2) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle("t3");
        end_test("t3", 1, 1);

        // 4: len=0 finishes without kicking the sorter
        begin_test();
        exp_sum_q.push_back(0);
        do_go(0);
        @(negedge clk);
        check("t4_done", {31'd0, done}, 32'd1);
        wait_idle("t4");
        end_test("t4", 1, 0);

        // words offered while idle are not accepted
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        check("idle_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 5: len=20 clipped to DEPTH=16
        begin_test();
        exp_sum_q.push_back(136);
        do_go(20);
        for (int i = 0; i < 16; i++) push_wr(i, i + 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle("t5");
        end_test("t5", 1, 1);

`ifdef SORT_LOADER_SUM_EN
        check("sum_queue_empty", exp_sum_q.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
